// File: rtl/oled_spi_writer.sv
// Byte-wide mode-3 SPI transmitter for SSD1331-class OLED panels, with CS_N/DC framing.
// Define OLED_SPI_CS_HOLD_EN to let DATA[9] keep CS_N low across consecutive transfers.
module oled_spi_writer #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       WRITE_START,
  input  logic [9:0] DATA,
  output logic       WRITE_DONE,
  output logic       BUSY,
  output logic       SCLK,
  output logic       MOSI,
  output logic       CS_N,
  output logic       DC
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  // HOLD runs one cycle past a half period so WRITE_DONE lands 18*H+1 edges after acceptance.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(CLK_DIV);

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [2:0]       r_bit, w_bit;
  logic             r_phase, w_phase;
  logic [7:0]       r_shift, w_shift;
  logic             r_armed, w_armed;
  logic             r_done, w_done;
  logic             r_busy, w_busy;
  logic             r_sclk, w_sclk;
  logic             r_mosi, w_mosi;
  logic             r_cs_n, w_cs_n;
  logic             r_dc, w_dc;
`ifdef OLED_SPI_CS_HOLD_EN
  logic             r_cs_hold, w_cs_hold;
`else
  logic             w_unused_cs_hold;
  assign w_unused_cs_hold = DATA[9];
`endif

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bit   = r_bit;
    w_phase = r_phase;
    w_shift = r_shift;
    w_armed = r_armed;
    w_done  = 1'b0;
    w_busy  = r_busy;
    w_sclk  = r_sclk;
    w_mosi  = r_mosi;
    w_cs_n  = r_cs_n;
    w_dc    = r_dc;
`ifdef OLED_SPI_CS_HOLD_EN
    w_cs_hold = r_cs_hold;
`endif
    case (r_state)
      S_IDLE: begin
        if (WRITE_START && r_armed) begin
          w_state = S_SETUP;
          w_cnt   = CNT_ZERO;
          w_bit   = 3'd0;
          w_phase = 1'b0;
          w_shift = DATA[7:0];
          w_dc    = DATA[8];
          w_cs_n  = 1'b0;
          w_mosi  = DATA[7];
          w_busy  = 1'b1;
          w_armed = 1'b0;
`ifdef OLED_SPI_CS_HOLD_EN
          w_cs_hold = DATA[9];
`endif
        end else if (!WRITE_START) begin
          w_armed = 1'b1;
        end else begin
          w_armed = r_armed;
        end
      end
      S_SETUP: begin
        if (r_cnt == HALF_LAST) begin
          w_state = S_SHIFT;
          w_cnt   = CNT_ZERO;
          w_sclk  = 1'b0;
          w_phase = 1'b0;
          w_bit   = 3'd0;
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt = CNT_ZERO;
          if (!r_phase) begin
            w_sclk  = 1'b1;
            w_phase = 1'b1;
          end else if (r_bit == 3'd7) begin
            w_state = S_HOLD;
          end else begin
            // Next bit is presented on the falling edge only.
            w_sclk  = 1'b0;
            w_phase = 1'b0;
            w_bit   = r_bit + 3'd1;
            w_shift = {r_shift[6:0], 1'b0};
            w_mosi  = r_shift[6];
          end
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_state = S_DONE;
          w_cnt   = CNT_ZERO;
          w_done  = 1'b1;
`ifdef OLED_SPI_CS_HOLD_EN
          w_cs_n  = ~r_cs_hold;
`else
          w_cs_n  = 1'b1;
`endif
        end else begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
      default: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
        w_cs_n  = 1'b1;
        w_sclk  = 1'b1;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt   <= CNT_ZERO;
      r_bit   <= 3'd0;
      r_phase <= 1'b0;
      r_shift <= 8'h00;
      r_armed <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_sclk  <= 1'b1;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_dc    <= 1'b0;
`ifdef OLED_SPI_CS_HOLD_EN
      r_cs_hold <= 1'b0;
`endif
    end else begin
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_phase <= w_phase;
      r_shift <= w_shift;
      r_armed <= w_armed;
      r_done  <= w_done;
      r_busy  <= w_busy;
      r_sclk  <= w_sclk;
      r_mosi  <= w_mosi;
      r_cs_n  <= w_cs_n;
      r_dc    <= w_dc;
`ifdef OLED_SPI_CS_HOLD_EN
      r_cs_hold <= w_cs_hold;
`endif
    end
  end

  assign WRITE_DONE = r_done;
  assign BUSY       = r_busy;
  assign SCLK       = r_sclk;
  assign MOSI       = r_mosi;
  assign CS_N       = r_cs_n;
  assign DC         = r_dc;

endmodule
